// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO mode constants and elaboration helpers
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit fifo_depth_ok(input int depth, input int ptrwidth);
    return depth == (1 << ptrwidth);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - push/pop/status bundle of the programmable sync FIFO
interface sync_fifo_prog_if #(
  parameter int DWIDTH   = 8,
  parameter int PTRWIDTH = 4
);
  logic                push;
  logic [DWIDTH-1:0]   wdata;
  logic                full;
  logic                almost_full;
  logic                pop;
  logic [DWIDTH-1:0]   rdata;
  logic                rvalid;
  logic                empty;
  logic                almost_empty;
  logic [PTRWIDTH:0]   count;
  logic [PTRWIDTH:0]   afull_thresh;
  logic [PTRWIDTH:0]   aempty_thresh;
  logic                overflow;
  logic                underflow;
  logic                clr_err;

  modport master (
    output push, wdata, pop, afull_thresh, aempty_thresh, clr_err,
    input  full, almost_full, rdata, rvalid, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  push, wdata, pop, afull_thresh, aempty_thresh, clr_err,
    output full, almost_full, rdata, rvalid, empty, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DEPTH x DWIDTH two-port RAM, registered or async read
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 8,
  parameter int REG_RD = 1,
  parameter int AWIDTH = fifo_log2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  generate
    if (REG_RD != 0) begin : g_reg
      // only the output register is reset; array contents are left as-is
      logic [DWIDTH-1:0] r_rdata;
      always_ff @(posedge clk) begin
        if (i_rst)     r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
      end
      assign o_rdata = r_rdata;
    end else begin : g_async
      logic w_unused;
      assign w_unused = &{1'b0, i_rst, i_re};
      assign o_rdata  = r_mem[i_raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with fill count, programmable thresholds and sticky errors
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PTRWIDTH = 4,
  parameter int DWIDTH   = 8,
  parameter int FWFT     = FIFO_MODE_STD
) (
  input  logic            clk,
  input  logic            reset,
  sync_fifo_prog_if.slave bus
);

  localparam logic [PTRWIDTH:0] CNT_DEPTH = (PTRWIDTH+1)'(DEPTH);

  generate
    if (!fifo_depth_ok(DEPTH, PTRWIDTH)) begin : g_bad_depth
      $error("sync_fifo_prog: DEPTH must equal 2**PTRWIDTH");
    end
  endgenerate

  logic [PTRWIDTH:0] r_wptr;
  logic [PTRWIDTH:0] r_rptr;
  logic [PTRWIDTH:0] r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_full;
  logic              w_empty;
  logic              w_push_acc;
  logic              w_pop_acc;
  logic [DWIDTH-1:0] w_rdata;

  // flags come from the registered count so pointer wrap never matters
  assign w_full     = (r_count == CNT_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_push_acc = bus.push && !w_full;
  assign w_pop_acc  = bus.pop && !w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop_acc)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // a new error sets even when clr_err is asserted in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.push && w_full) r_overflow <= 1'b1;
      else if (bus.clr_err)   r_overflow <= 1'b0;
      if (bus.pop && w_empty) r_underflow <= 1'b1;
      else if (bus.clr_err)   r_underflow <= 1'b0;
    end
  end

  fifo_mem_2p #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH),
    .REG_RD ((FWFT == FIFO_MODE_STD) ? 1 : 0),
    .AWIDTH (PTRWIDTH)
  ) u_mem (
    .clk     (clk),
    .i_rst   (reset),
    .i_we    (w_push_acc),
    .i_waddr (r_wptr[PTRWIDTH-1:0]),
    .i_wdata (bus.wdata),
    .i_re    (w_pop_acc),
    .i_raddr (r_rptr[PTRWIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_STD) begin : g_std
      logic r_rvalid;
      always_ff @(posedge clk) begin
        if (reset) r_rvalid <= 1'b0;
        else       r_rvalid <= w_pop_acc;
      end
      assign bus.rvalid = r_rvalid;
    end else begin : g_fwft
      assign bus.rvalid = !w_empty;
    end
  endgenerate

  assign bus.rdata        = w_rdata;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= bus.afull_thresh);
  assign bus.almost_empty = (r_count <= bus.aempty_thresh);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - directed self-checking bench for sync_fifo_prog (standard and FWFT)
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DWIDTH(8), .PTRWIDTH(4)) bs ();
  sync_fifo_prog_if #(.DWIDTH(8), .PTRWIDTH(4)) bf ();

  sync_fifo_prog #(.DEPTH(16), .PTRWIDTH(4), .DWIDTH(8), .FWFT(0)) dut_std (
    .clk   (clk),
    .reset (reset),
    .bus   (bs)
  );

  sync_fifo_prog #(.DEPTH(16), .PTRWIDTH(4), .DWIDTH(8), .FWFT(1)) dut_fwft (
    .clk   (clk),
    .reset (reset),
    .bus   (bf)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic [7:0] exp_rd;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bs.push = 0; bs.pop = 0; bs.wdata = '0; bs.clr_err = 0;
    bf.push = 0; bf.pop = 0; bf.wdata = '0; bf.clr_err = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    idle_inputs();
    bs.afull_thresh = 5'd12; bs.aempty_thresh = 5'd3;
    bf.afull_thresh = 5'd12; bf.aempty_thresh = 5'd3;
    step(); step();
    reset = 0;
    checks++; if (bs.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bs.count); end
    checks++; if (bs.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bs.empty); end
    checks++; if (bs.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bs.full); end
    checks++; if (bs.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", bs.rvalid); end
    checks++; if (bs.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", bs.rdata); end
    checks++; if (bs.overflow !== 1'b0 || bs.underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", bs.overflow, bs.underflow); end
    checks++; if (bf.rvalid !== 1'b0 || bf.empty !== 1'b1) begin errors++; $display("FAIL reset_fwft got rvalid=%b empty=%b want 0 1", bf.rvalid, bf.empty); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      bs.push = 1; bs.wdata = i[7:0];
      step();
      checks++; if (bs.count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bs.count, i + 1); end
    end
    checks++; if (bs.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bs.full); end
    checks++; if (bs.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b want 0", bs.overflow); end
    bs.wdata = 8'hFF;
    step();
    bs.push = 0;
    checks++; if (bs.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bs.overflow); end
    checks++; if (bs.count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", bs.count); end
  endtask

  task automatic test_drain;
    bs.pop = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (bs.rvalid !== 1'b1 || bs.rdata !== i[7:0]) begin errors++; $display("FAIL drain[%0d] got rvalid=%b rdata=%h want 1 %h", i, bs.rvalid, bs.rdata, i[7:0]); end
    end
    checks++; if (bs.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", bs.empty); end
    checks++; if (bs.underflow !== 1'b0) begin errors++; $display("FAIL drain_no_udf got %b want 0", bs.underflow); end
    step();
    bs.pop = 0;
    checks++; if (bs.underflow !== 1'b1) begin errors++; $display("FAIL udf_set got %b want 1", bs.underflow); end
    checks++; if (bs.rvalid !== 1'b0) begin errors++; $display("FAIL udf_rvalid got %b want 0", bs.rvalid); end
    checks++; if (bs.rdata !== 8'h0F) begin errors++; $display("FAIL udf_rdata_hold got %h want 0f", bs.rdata); end
    bs.clr_err = 1;
    step();
    bs.clr_err = 0;
    checks++; if (bs.overflow !== 1'b0 || bs.underflow !== 1'b0) begin errors++; $display("FAIL clr_err got %b%b want 00", bs.overflow, bs.underflow); end
  endtask

  task automatic test_thresholds;
    checks++; if (bs.almost_empty !== 1'b1 || bs.almost_full !== 1'b0) begin errors++; $display("FAIL thr_at0 got ae=%b af=%b want 1 0", bs.almost_empty, bs.almost_full); end
    for (int k = 1; k <= 12; k++) begin
      bs.push = 1; bs.wdata = k[7:0];
      step();
      checks++; if (bs.almost_full !== (k >= 12)) begin errors++; $display("FAIL thr_af[%0d] got %b want %b", k, bs.almost_full, (k >= 12)); end
      checks++; if (bs.almost_empty !== (k <= 3)) begin errors++; $display("FAIL thr_ae[%0d] got %b want %b", k, bs.almost_empty, (k <= 3)); end
    end
    bs.push = 0; bs.pop = 1;
    step();
    bs.pop = 0;
    checks++; if (bs.count !== 5'd11 || bs.almost_full !== 1'b0) begin errors++; $display("FAIL thr_af_drop got count=%0d af=%b want 11 0", bs.count, bs.almost_full); end
    checks++; if (bs.rdata !== 8'h01) begin errors++; $display("FAIL thr_first_rd got %h want 01", bs.rdata); end
    bs.afull_thresh = 5'd0; #1;
    checks++; if (bs.almost_full !== 1'b1) begin errors++; $display("FAIL thr_af_zero got %b want 1", bs.almost_full); end
    bs.afull_thresh = 5'd11; #1;
    checks++; if (bs.almost_full !== 1'b1) begin errors++; $display("FAIL thr_af_eq got %b want 1", bs.almost_full); end
    bs.aempty_thresh = 5'd11; #1;
    checks++; if (bs.almost_empty !== 1'b1) begin errors++; $display("FAIL thr_ae_eq got %b want 1", bs.almost_empty); end
    bs.afull_thresh = 5'd12; bs.aempty_thresh = 5'd3; #1;
    checks++; if (bs.almost_full !== 1'b0 || bs.almost_empty !== 1'b0) begin errors++; $display("FAIL thr_restore got af=%b ae=%b want 0 0", bs.almost_full, bs.almost_empty); end
    bs.pop = 1;
    for (int k = 0; k < 11; k++) step();
    bs.pop = 0;
    checks++; if (bs.empty !== 1'b1) begin errors++; $display("FAIL thr_drain_empty got %b want 1", bs.empty); end
  endtask

  task automatic test_back_to_back;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      bs.push = 1; bs.wdata = 8'h40 + i[7:0]; q.push_back(8'h40 + i[7:0]);
      step();
    end
    checks++; if (bs.count !== 5'd5) begin errors++; $display("FAIL b2b_start got %0d want 5", bs.count); end
    bs.pop = 1;
    for (int c = 0; c < 40; c++) begin
      bs.wdata = 8'h80 + c[7:0];
      step();
      exp_rd = q.pop_front();
      q.push_back(8'h80 + c[7:0]);
      checks++; if (bs.count !== 5'd5) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 5", c, bs.count); end
      checks++; if (bs.rvalid !== 1'b1 || bs.rdata !== exp_rd) begin errors++; $display("FAIL b2b_data[%0d] got rvalid=%b rdata=%h want 1 %h", c, bs.rvalid, bs.rdata, exp_rd); end
    end
    bs.pop = 0;
    for (int i = 0; i < 11; i++) begin
      bs.wdata = 8'hC0 + i[7:0]; q.push_back(8'hC0 + i[7:0]);
      step();
    end
    checks++; if (bs.full !== 1'b1 || bs.overflow !== 1'b0) begin errors++; $display("FAIL b2b_full got full=%b ovf=%b want 1 0", bs.full, bs.overflow); end
    bs.pop = 1; bs.wdata = 8'hEE;
    step();
    exp_rd = q.pop_front();
    bs.push = 0; bs.pop = 0;
    checks++; if (bs.count !== 5'd15) begin errors++; $display("FAIL full_pp_count got %0d want 15", bs.count); end
    checks++; if (bs.overflow !== 1'b1) begin errors++; $display("FAIL full_pp_ovf got %b want 1", bs.overflow); end
    checks++; if (bs.rvalid !== 1'b1 || bs.rdata !== exp_rd) begin errors++; $display("FAIL full_pp_data got rvalid=%b rdata=%h want 1 %h", bs.rvalid, bs.rdata, exp_rd); end
  endtask

  task automatic test_reset_mid;
    bs.pop = 1;
    for (int i = 0; i < 6; i++) step();
    checks++; if (bs.count !== 5'd9) begin errors++; $display("FAIL mid_pre_count got %0d want 9", bs.count); end
    bs.push = 1; bs.wdata = 8'h55;
    reset = 1;
    step();
    reset = 0; bs.push = 0; bs.pop = 0;
    checks++; if (bs.count !== 5'd0 || bs.empty !== 1'b1) begin errors++; $display("FAIL mid_reset got count=%0d empty=%b want 0 1", bs.count, bs.empty); end
    checks++; if (bs.rvalid !== 1'b0 || bs.overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got rvalid=%b ovf=%b want 0 0", bs.rvalid, bs.overflow); end
  endtask

  task automatic test_clr_set;
    bs.push = 1;
    for (int i = 0; i < 17; i++) begin
      bs.wdata = i[7:0];
      step();
    end
    checks++; if (bs.overflow !== 1'b1 || bs.count !== 5'd16) begin errors++; $display("FAIL cs_pre got ovf=%b count=%0d want 1 16", bs.overflow, bs.count); end
    bs.clr_err = 1;
    step();
    checks++; if (bs.overflow !== 1'b1) begin errors++; $display("FAIL cs_set_wins got %b want 1", bs.overflow); end
    bs.push = 0;
    step();
    bs.clr_err = 0;
    checks++; if (bs.overflow !== 1'b0 || bs.count !== 5'd16) begin errors++; $display("FAIL cs_clear got ovf=%b count=%0d want 0 16", bs.overflow, bs.count); end
  endtask

  task automatic test_fwft;
    checks++; if (bf.rvalid !== 1'b0) begin errors++; $display("FAIL fwft_idle got rvalid=%b want 0", bf.rvalid); end
    bf.push = 1; bf.wdata = 8'hA5;
    step();
    bf.push = 0;
    checks++; if (bf.rvalid !== 1'b1 || bf.rdata !== 8'hA5) begin errors++; $display("FAIL fwft_show got rvalid=%b rdata=%h want 1 a5", bf.rvalid, bf.rdata); end
    checks++; if (bf.count !== 5'd1) begin errors++; $display("FAIL fwft_count got %0d want 1", bf.count); end
    bf.pop = 1;
    step();
    bf.pop = 0;
    checks++; if (bf.empty !== 1'b1 || bf.rvalid !== 1'b0) begin errors++; $display("FAIL fwft_pop got empty=%b rvalid=%b want 1 0", bf.empty, bf.rvalid); end
    bf.push = 1; bf.wdata = 8'h11; step();
    bf.wdata = 8'h22; step();
    bf.push = 0;
    checks++; if (bf.rdata !== 8'h11) begin errors++; $display("FAIL fwft_head got %h want 11", bf.rdata); end
    bf.pop = 1; step(); bf.pop = 0;
    checks++; if (bf.rdata !== 8'h22 || bf.rvalid !== 1'b1) begin errors++; $display("FAIL fwft_next got rdata=%h rvalid=%b want 22 1", bf.rdata, bf.rvalid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_thresholds();
    test_back_to_back();
    test_reset_mid();
    test_clr_set();
    test_fwft();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised successor to the team's async FIFO, intended for same-domain buffering between datapath stages.
- Adds a fill count, runtime-programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Selectable output mode: standard registered read or first-word-fall-through (FWFT).
- Keeps the push/pop/full/empty handshake of the async FIFO.

Parameters:
- DEPTH, 16, number of entries; must equal 2**PTRWIDTH.
- PTRWIDTH, 4, address width; pointers and count are PTRWIDTH+1 bits.
- DWIDTH, 8, data width.
- FWFT, 0, output mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request.
- wdata  in  DWIDTH  write data, sampled with push.
- full  out  1  high when count == DEPTH.
- almost_full  out  1  high when count >= afull_thresh.
- pop  in  1  read request.
- rdata  out  DWIDTH  read data.
- rvalid  out  1  rdata qualifier.
- empty  out  1  high when count == 0.
- almost_empty  out  1  high when count <= aempty_thresh.
- count  out  PTRWIDTH+1  current fill level, 0..DEPTH.
- afull_thresh  in  PTRWIDTH+1  almost-full threshold.
- aempty_thresh  in  PTRWIDTH+1  almost-empty threshold.
- overflow  out  1  sticky; a push was issued while full.
- underflow  out  1  sticky; a pop was issued while empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (synchronous, active-high, takes priority over all other inputs):
  - wptr = rptr = count = 0; empty = 1; full = 0.
  - overflow = underflow = 0; rvalid = 0; rdata = 0 in standard mode.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored entries.
- Accepted push = push && !full. Accepted pop = pop && !empty. Both are evaluated on pre-edge flags.
- Rejected operations leave pointers, count and memory unchanged.
- Push when full with a simultaneous pop: the push is rejected and the pop is accepted (count decrements by 1).
- Pop when empty with a simultaneous push: the pop is rejected and the push is accepted (count becomes 1).
- Pointers increment modulo 2**(PTRWIDTH+1). Memory address is ptr[PTRWIDTH-1:0].
- Full/empty are decided from count, not from the pointer MSB compare.
- count next value:
  - +1 on accepted push only;
  - -1 on accepted pop only;
  - unchanged when both or neither are accepted.
- full, empty, almost_full and almost_empty are combinational from the registered count.
  - They therefore reflect an operation accepted at edge k immediately after edge k.
  - Thresholds are compared unsigned.
  - afull_thresh = 0 gives almost_full = 1 always.
  - Thresholds may change at any time; the flags follow within the same cycle.
- Standard mode (FWFT = 0):
  - Accepted pop at edge k loads rdata = mem[rptr] at edge k and sets rvalid = 1 for exactly that cycle.
  - Pop latency is 1 cycle; rdata holds its value otherwise.
  - rvalid = 0 after a rejected pop.
- FWFT mode (FWFT = 1):
  - rdata = mem[rptr[PTRWIDTH-1:0]] is read combinationally; rvalid = !empty.
  - Pop acknowledges the displayed head word.
  - After a push into an empty FIFO at edge k, the word is visible after edge k.
- Error flags:
  - overflow sets on push && full; underflow sets on pop && empty.
  - clr_err clears both.
  - Set wins over clr_err in the same cycle.
- Write and read of the same address in one cycle are only possible when count is 0 or DEPTH, and the accept rules above exclude it.

Decomposition:
- Shared package/header fifo_pkg:
  - FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1;
  - the log2 helper function;
  - the DEPTH == 2**PTRWIDTH elaboration check.
- One sub-module, fifo_mem_2p:
  - DEPTH x DWIDTH array with one synchronous write port and one read port.
  - The read port is registered or asynchronous, selected by parameter.
- Control logic (pointers, count, flags, error flags) stays in sync_fifo_prog.

Test Plan:
- Reset, then 16 pushes of 0x00..0x0F with no pops -> count steps 1..16, full = 1 after the 16th edge; a 17th push sets overflow = 1 and count stays 16.
- 16 pops after the fill (FWFT = 0) -> rdata = 0x00..0x0F in order, each with rvalid one cycle after its pop; empty = 1 after the last; an extra pop sets underflow = 1 and rvalid = 0.
- FWFT = 1: push 0xA5 into an empty FIFO -> the next cycle shows rvalid = 1, rdata = 0xA5 with no pop; pop -> empty = 1 the following cycle.
- afull_thresh = 12, aempty_thresh = 3; fill to 12 -> almost_full goes high at count 12 and low at 11; almost_empty is high for count 0..3 and low at 4.
- Simultaneous push+pop at count 5 for 40 cycles with wrap-around -> count stays 5 and data order is preserved; the same at count 16 -> push rejected, count 15, overflow = 1.
- Assert reset at count 9 -> next cycle count = 0, empty = 1, rvalid = 0; clr_err with overflow set plus a push on full in the same cycle -> overflow stays 1.
